// File: rtl/regfile_pkg.sv
// Shared sizing helpers for the 2R1W register file.
// Combinational constants only; no latency, no backpressure.
package regfile_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Address width for a register count, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic bit rd_lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/regfile_2r1w_rd_port_pipe.sv
// One read port: range check, write bypass and RD_LAT output stage(s).
// Latency RD_LAT (1 or 2) cycles; no backpressure, one valid pulse per request.
module rd_port_pipe
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = clog2_min1(DEF_DEPTH),
  parameter int RD_LAT = 1,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_word,
  input  logic              wr_acc,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_vld,
  output logic              rd_err
);

  logic              in_range;
  logic [DATA_W-1:0] nxt_data;
  logic              s1_vld;
  logic              s1_err;
  logic [DATA_W-1:0] s1_data;

  assign in_range = 32'(rd_addr) < DEPTH;

  // Only accepted writes reach this mux, so rejected writes are never bypassed.
  always_comb begin
    nxt_data = rd_word;
    if (!in_range) begin
      nxt_data = '0;
    end else if (BYPASS && wr_acc && (wr_addr == rd_addr)) begin
      nxt_data = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld  <= 1'b0;
      s1_err  <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_vld <= rd_en;
      s1_err <= rd_en && !in_range;
      if (rd_en) s1_data <= nxt_data;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              s2_vld;
    logic              s2_err;
    logic [DATA_W-1:0] s2_data;

    always_ff @(posedge clk) begin
      if (!rst) begin
        s2_vld  <= 1'b0;
        s2_err  <= 1'b0;
        s2_data <= '0;
      end else begin
        s2_vld <= s1_vld;
        s2_err <= s1_err;
        if (s1_vld) s2_data <= s1_data;
      end
    end

    assign rd_vld  = s2_vld;
    assign rd_err  = s2_err;
    assign rd_data = s2_data;
  end else begin : g_lat1
    assign rd_vld  = s1_vld;
    assign rd_err  = s1_err;
    assign rd_data = s1_data;
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Register file, one write and two read ports, read-only mask and cfg_regs tap.
// Reads return after RD_LAT cycles, writes land at the edge; no backpressure.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int                DATA_W  = DEF_DATA_W,
  parameter int                DEPTH   = DEF_DEPTH,
  parameter int                NUM_CFG = 4,
  parameter int                RD_LAT  = 1,
  parameter bit                BYPASS  = 1'b1,
  parameter logic [DEPTH-1:0]  RO_MASK = '0,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  localparam int               ADDR_W  = clog2_min1(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wrEn,
  input  logic [ADDR_W-1:0]         wrAddr,
  input  logic [DATA_W-1:0]         wrData,
  input  logic                      rdEn_a,
  input  logic [ADDR_W-1:0]         rdAddr_a,
  input  logic                      rdEn_b,
  input  logic [ADDR_W-1:0]         rdAddr_b,
  output logic [DATA_W-1:0]         rdData_a,
  output logic [DATA_W-1:0]         rdData_b,
  output logic                      rdData_valid_a,
  output logic                      rdData_valid_b,
  output logic                      rd_err_a,
  output logic                      rd_err_b,
  output logic                      wr_err,
  output logic [NUM_CFG*DATA_W-1:0] cfg_regs
);

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
    $error("regfile_2r1w: RD_LAT must be 1 or 2");
  end
  if ((NUM_CFG < 1) || (NUM_CFG > DEPTH)) begin : g_bad_cfg
    $error("regfile_2r1w: NUM_CFG must be within 1..DEPTH");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_acc;
  logic [DATA_W-1:0] rd_word_a;
  logic [DATA_W-1:0] rd_word_b;

  // The RO lookup is only evaluated for in-range addresses.
  always_comb begin
    wr_acc = 1'b0;
    if (wrEn && (32'(wrAddr) < DEPTH)) wr_acc = !RO_MASK[wrAddr];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
      wr_err <= 1'b0;
    end else begin
      if (wr_acc) mem[wrAddr] <= wrData;
      wr_err <= wrEn && !wr_acc;
    end
  end

  assign rd_word_a = (32'(rdAddr_a) < DEPTH) ? mem[rdAddr_a] : '0;
  assign rd_word_b = (32'(rdAddr_b) < DEPTH) ? mem[rdAddr_b] : '0;

  rd_port_pipe #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT),
    .BYPASS (BYPASS)
  ) u_rd_a (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rdEn_a),
    .rd_addr (rdAddr_a),
    .rd_word (rd_word_a),
    .wr_acc  (wr_acc),
    .wr_addr (wrAddr),
    .wr_data (wrData),
    .rd_data (rdData_a),
    .rd_vld  (rdData_valid_a),
    .rd_err  (rd_err_a)
  );

  rd_port_pipe #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT),
    .BYPASS (BYPASS)
  ) u_rd_b (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rdEn_b),
    .rd_addr (rdAddr_b),
    .rd_word (rd_word_b),
    .wr_acc  (wr_acc),
    .wr_addr (wrAddr),
    .wr_data (wrData),
    .rd_data (rdData_b),
    .rd_vld  (rdData_valid_b),
    .rd_err  (rd_err_b)
  );

  for (genvar i = 0; i < NUM_CFG; i++) begin : g_cfg
    assign cfg_regs[i*DATA_W +: DATA_W] = mem[i];
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Drives three register-file configurations with shared stimulus and checks
// every output each cycle against an array-based model, plus literal pins.
module tb_regfile_2r1w;

  localparam int NDUT = 3;
  localparam int          DEPTH_C [NDUT] = '{16, 12, 12};
  localparam int          LAT_C   [NDUT] = '{1, 2, 2};
  localparam bit          BYP_C   [NDUT] = '{1'b1, 1'b1, 1'b0};
  localparam logic [15:0] RO_C    [NDUT] = '{16'h0000, 16'h0002, 16'h0002};
  localparam logic [7:0]  RSTV_C  [NDUT] = '{8'h00, 8'h3C, 8'h3C};

  typedef struct packed {
    logic       vld;
    logic       err;
    logic [7:0] dat;
  } rd_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       wrEn;
  logic [3:0] wrAddr;
  logic [7:0] wrData;
  logic       rdEn_a, rdEn_b;
  logic [3:0] rdAddr_a, rdAddr_b;

  logic [7:0]  rd_dat [NDUT][2];
  logic        rd_vld [NDUT][2];
  logic        rd_err [NDUT][2];
  logic        wr_err_o [NDUT];
  logic [31:0] cfg [NDUT];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  regfile_2r1w #(.DATA_W(8), .DEPTH(16), .NUM_CFG(4), .RD_LAT(1), .BYPASS(1'b1),
                 .RO_MASK(16'h0000), .RST_VAL(8'h00)) u_dut0 (
    .clk(clk), .rst(rst), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .rdEn_a(rdEn_a), .rdAddr_a(rdAddr_a), .rdEn_b(rdEn_b), .rdAddr_b(rdAddr_b),
    .rdData_a(rd_dat[0][0]), .rdData_b(rd_dat[0][1]),
    .rdData_valid_a(rd_vld[0][0]), .rdData_valid_b(rd_vld[0][1]),
    .rd_err_a(rd_err[0][0]), .rd_err_b(rd_err[0][1]),
    .wr_err(wr_err_o[0]), .cfg_regs(cfg[0]));

  regfile_2r1w #(.DATA_W(8), .DEPTH(12), .NUM_CFG(4), .RD_LAT(2), .BYPASS(1'b1),
                 .RO_MASK(12'h002), .RST_VAL(8'h3C)) u_dut1 (
    .clk(clk), .rst(rst), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .rdEn_a(rdEn_a), .rdAddr_a(rdAddr_a), .rdEn_b(rdEn_b), .rdAddr_b(rdAddr_b),
    .rdData_a(rd_dat[1][0]), .rdData_b(rd_dat[1][1]),
    .rdData_valid_a(rd_vld[1][0]), .rdData_valid_b(rd_vld[1][1]),
    .rd_err_a(rd_err[1][0]), .rd_err_b(rd_err[1][1]),
    .wr_err(wr_err_o[1]), .cfg_regs(cfg[1]));

  regfile_2r1w #(.DATA_W(8), .DEPTH(12), .NUM_CFG(4), .RD_LAT(2), .BYPASS(1'b0),
                 .RO_MASK(12'h002), .RST_VAL(8'h3C)) u_dut2 (
    .clk(clk), .rst(rst), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .rdEn_a(rdEn_a), .rdAddr_a(rdAddr_a), .rdEn_b(rdEn_b), .rdAddr_b(rdAddr_b),
    .rdData_a(rd_dat[2][0]), .rdData_b(rd_dat[2][1]),
    .rdData_valid_a(rd_vld[2][0]), .rdData_valid_b(rd_vld[2][1]),
    .rd_err_a(rd_err[2][0]), .rd_err_b(rd_err[2][1]),
    .wr_err(wr_err_o[2]), .cfg_regs(cfg[2]));

  // Model: register contents, per-port history of request results, expected outputs.
  logic [7:0] m_mem [NDUT][16];
  rd_t        hist  [NDUT][2][2];
  logic [7:0] e_dat [NDUT][2];
  logic       e_vld [NDUT][2];
  logic       e_err [NDUT][2];
  logic       e_wr_err [NDUT];

  function automatic rd_t read_result(input int k, input logic en, input logic [3:0] a,
                                      input logic acc);
    rd_t r;
    r = '0;
    if (en) begin
      r.vld = 1'b1;
      if (int'(a) >= DEPTH_C[k]) r.err = 1'b1;
      else if (BYP_C[k] && acc && (a == wrAddr)) r.dat = wrData;
      else r.dat = m_mem[k][a];
    end
    return r;
  endfunction

  always @(posedge clk) begin : model
    logic acc;
    rd_t  r;
    for (int k = 0; k < NDUT; k++) begin
      acc = wrEn && (int'(wrAddr) < DEPTH_C[k]) && !RO_C[k][wrAddr];
      if (!rst) begin
        for (int m = 0; m < 16; m++) m_mem[k][m] = RSTV_C[k];
        for (int p = 0; p < 2; p++) begin
          hist[k][p][0] = '0;
          hist[k][p][1] = '0;
          e_dat[k][p] = 8'h00;
          e_vld[k][p] = 1'b0;
          e_err[k][p] = 1'b0;
        end
        e_wr_err[k] = 1'b0;
      end else begin
        for (int p = 0; p < 2; p++) begin
          r = (p == 0) ? read_result(k, rdEn_a, rdAddr_a, acc)
                       : read_result(k, rdEn_b, rdAddr_b, acc);
          hist[k][p][1] = hist[k][p][0];
          hist[k][p][0] = r;
          r = hist[k][p][LAT_C[k]-1];
          e_vld[k][p] = r.vld;
          e_err[k][p] = r.err;
          if (r.vld) e_dat[k][p] = r.dat;
        end
        e_wr_err[k] = wrEn && !acc;
        if (acc) m_mem[k][wrAddr] = wrData;
      end
    end
  end

  task automatic check(input string nm, input int k, input int p,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d port%0d t=%0t actual=%h expected=%h", nm, k, p, $time, act, exp);
    end
  endtask

  task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NDUT; k++) begin
        for (int p = 0; p < 2; p++) begin
          check("rd_data", k, p, 32'(rd_dat[k][p]), 32'(e_dat[k][p]));
          check("rd_valid", k, p, 32'(rd_vld[k][p]), 32'(e_vld[k][p]));
          check("rd_err", k, p, 32'(rd_err[k][p]), 32'(e_err[k][p]));
        end
        check("wr_err", k, 0, 32'(wr_err_o[k]), 32'(e_wr_err[k]));
        check("cfg_regs", k, 0, cfg[k],
              {m_mem[k][3], m_mem[k][2], m_mem[k][1], m_mem[k][0]});
      end
    end
  end

  task automatic step(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                      input logic ea, input logic [3:0] aa,
                      input logic eb, input logic [3:0] ab);
    wrEn = we; wrAddr = wa; wrData = wd;
    rdEn_a = ea; rdAddr_a = aa;
    rdEn_b = eb; rdAddr_b = ab;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 4'd0);
  endtask

  initial begin
    logic       we, ea, eb;
    logic [3:0] wa, aa, ab;
    logic [7:0] wd;

    rst = 1'b0;
    wrEn = 1'b0; wrAddr = 4'd0; wrData = 8'h00;
    rdEn_a = 1'b0; rdAddr_a = 4'd0; rdEn_b = 1'b0; rdAddr_b = 4'd0;
    idle();
    chk_en = 1'b1;
    idle();
    pin("rst_valid_a", 32'(rd_vld[0][0]), 32'd0);
    pin("rst_cfg_dut1", cfg[1], 32'h3C3C_3C3C);
    rst = 1'b1;

    // Reset readback sweep on port A.
    for (int a = 0; a < 16; a++) begin
      step(1'b0, 4'd0, 8'h00, 1'b1, 4'(a), 1'b0, 4'd0);
      if (a == 0) pin("t1_valid0", 32'(rd_vld[0][0]), 32'd1);
      if (a == 1) pin("t1_rstval_lat2", 32'(rd_dat[1][0]), 32'h3C);
    end
    idle();
    pin("t1_oor_err_lat2", 32'(rd_err[1][0]), 32'd1);
    pin("t1_oor_data_lat2", 32'(rd_dat[1][0]), 32'h00);
    pin("t1_pulse_end", 32'(rd_vld[0][0]), 32'd0);

    // Write then dual-port read of the same register.
    step(1'b1, 4'd5, 8'h0A, 1'b0, 4'd0, 1'b0, 4'd0);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 1'b1, 4'd5);
    pin("t2_a_lat1", 32'(rd_dat[0][0]), 32'h0A);
    pin("t2_b_lat1", 32'(rd_dat[0][1]), 32'h0A);
    pin("t2_vld_pair", {31'd0, rd_vld[0][0] & rd_vld[0][1]}, 32'd1);
    idle();
    pin("t2_a_lat2", 32'(rd_dat[1][0]), 32'h0A);
    pin("t2_b_lat2", 32'(rd_dat[2][1]), 32'h0A);

    // Same-edge write and read: bypass vs prior value.
    step(1'b1, 4'd3, 8'h07, 1'b0, 4'd0, 1'b0, 4'd0);
    step(1'b1, 4'd3, 8'h0F, 1'b1, 4'd3, 1'b0, 4'd0);
    pin("t3_bypass_lat1", 32'(rd_dat[0][0]), 32'h0F);
    idle();
    pin("t3_bypass_lat2", 32'(rd_dat[1][0]), 32'h0F);
    pin("t3_nobypass_lat2", 32'(rd_dat[2][0]), 32'h07);

    // Out-of-range write and read on the 12-entry configurations.
    step(1'b1, 4'd13, 8'h99, 1'b0, 4'd0, 1'b0, 4'd0);
    pin("t4_wr_err_oor", 32'(wr_err_o[1]), 32'd1);
    pin("t4_wr_ok_d16", 32'(wr_err_o[0]), 32'd0);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd13, 1'b0, 4'd0);
    pin("t4_wr_err_pulse", 32'(wr_err_o[1]), 32'd0);
    idle();
    pin("t4_rd_err", 32'(rd_err[1][0]), 32'd1);
    pin("t4_rd_data0", 32'(rd_dat[1][0]), 32'h00);
    pin("t4_rd_vld", 32'(rd_vld[1][0]), 32'd1);
    pin("t4_hold_d16", 32'(rd_dat[0][0]), 32'h99);

    // Read-only register rejects writes; its neighbour accepts.
    step(1'b1, 4'd1, 8'hFF, 1'b0, 4'd0, 1'b0, 4'd0);
    pin("t5_ro_wr_err", 32'(wr_err_o[1]), 32'd1);
    pin("t5_ro_hold", 32'(cfg[1][15:8]), 32'h3C);
    pin("t5_rw_cfg", 32'(cfg[0][15:8]), 32'hFF);
    step(1'b1, 4'd2, 8'h55, 1'b0, 4'd0, 1'b0, 4'd0);
    pin("t5_cfg2", 32'(cfg[1][23:16]), 32'h55);

    // Reset in the middle of a read burst.
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd0, 1'b0, 4'd0);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd1, 1'b0, 4'd0);
    rst = 1'b0;
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 1'b0, 4'd0);
    step(1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 1'b0, 4'd0);
    rst = 1'b1;
    idle();
    pin("t6_no_vld_lat2", 32'(rd_vld[1][0]), 32'd0);
    pin("t6_no_vld_lat1", 32'(rd_vld[0][0]), 32'd0);
    idle();
    pin("t6_no_vld_late", 32'(rd_vld[2][0]), 32'd0);
    pin("t6_cfg_rst_dut1", cfg[1], 32'h3C3C_3C3C);
    pin("t6_cfg_rst_dut0", cfg[0], 32'h0000_0000);

    // Randomised traffic with address collisions and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 63) != 0);
      we = 1'($urandom);
      wa = 4'($urandom);
      wd = 8'($urandom);
      ea = 1'($urandom);
      eb = 1'($urandom);
      aa = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom);
      ab = ($urandom_range(0, 2) == 0) ? aa : 4'($urandom);
      step(we, wa, wd, ea, aa, eb, ab);
    end
    rst = 1'b1;
    idle();
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
